// File: rtl/unidad_mult_div.sv
// unidad_mult_div: iterative 32-bit MULT/MULTU/DIV/DIVU unit with HI/LO registers
//   Ports: clk_i, rst_i (async, active-high), start_i, op_i[1:0] (00 MULT, 01 MULTU,
//   10 DIV, 11 DIVU), operand_a_i/operand_b_i (rs/rt, sampled only at the accepting edge),
//   busy_o, done_o (one-cycle pulse), div_zero_o, hi_o, lo_o.
//   Optional MD_MTHILO_EN: adds we_hi_i/we_lo_i to load HI/LO from operand_a_i while idle.
module unidad_mult_div (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] operand_a_i,
    input  logic [31:0] operand_b_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        div_zero_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
`ifdef MD_MTHILO_EN
    ,
    input  logic        we_hi_i,
    input  logic        we_lo_i
`endif
);
    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;
    state_t      state_q;
    logic [1:0]  op_q;
    logic [31:0] m_q;
    logic [63:0] acc_q;
    logic [63:0] acc_d;
    logic [4:0]  cnt_q;
    logic        qneg_q;
    logic        rneg_q;
    logic        busy_q;
    logic        done_q;
    logic        dz_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        sgn;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_abs;
    logic [31:0] b_abs;
    logic [32:0] madd;
    logic [32:0] rsh;
    logic [32:0] diff;
    logic [63:0] prod;
    logic [31:0] fin_hi;
    logic [31:0] fin_lo;
    always_comb begin
        sgn   = ~op_i[0];
        a_neg = sgn & operand_a_i[31];
        b_neg = sgn & operand_b_i[31];
        a_abs = a_neg ? -operand_a_i : operand_a_i;
        b_abs = b_neg ? -operand_b_i : operand_b_i;
        // multiply: acc = {partial, multiplier}; add multiplicand on LSB, shift right
        madd  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, m_q} : 33'd0);
        // divide: acc = {remainder, dividend}; shift left, trial subtract, restore on borrow
        rsh   = acc_q[63:31];
        diff  = rsh - {1'b0, m_q};
        acc_d = op_q[1] ? (diff[32] ? {rsh[31:0], acc_q[30:0], 1'b0} : {diff[31:0], acc_q[30:0], 1'b1})
                        : {madd, acc_q[31:1]};
        prod  = qneg_q ? -acc_q : acc_q;
        fin_hi = op_q[1] ? (rneg_q ? -acc_q[63:32] : acc_q[63:32]) : prod[63:32];
        fin_lo = op_q[1] ? (qneg_q ? -acc_q[31:0] : acc_q[31:0]) : prod[31:0];
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            op_q    <= 2'b00;
            m_q     <= 32'd0;
            acc_q   <= 64'd0;
            cnt_q   <= 5'd0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        op_q   <= op_i;
                        m_q    <= op_i[1] ? b_abs : a_abs;
                        cnt_q  <= 5'd0;
                        dz_q   <= 1'b0;
                        busy_q <= 1'b1;
                        rneg_q <= a_neg;
                        if (op_i[1] && operand_b_i == 32'd0) begin
                            // divide by zero: skip CALC; remainder sign fix restores the raw dividend
                            acc_q   <= {a_abs, 32'hFFFF_FFFF};
                            qneg_q  <= 1'b0;
                            state_q <= FIN;
                        end else begin
                            acc_q   <= {32'd0, op_i[1] ? a_abs : b_abs};
                            qneg_q  <= a_neg ^ b_neg;
                            state_q <= CALC;
                        end
                    end
`ifdef MD_MTHILO_EN
                    else begin
                        if (we_hi_i) hi_q <= operand_a_i;
                        if (we_lo_i) lo_q <= operand_a_i;
                    end
`endif
                end
                CALC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) state_q <= FIN;
                end
                default: begin
                    hi_q    <= fin_hi;
                    lo_q    <= fin_lo;
                    dz_q    <= op_q[1] && m_q == 32'd0;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign div_zero_o = dz_q;
    assign hi_o       = hi_q;
    assign lo_o       = lo_q;
endmodule

// File: tb/tb_unidad_mult_div.sv
// tb_unidad_mult_div: directed self-checking bench for unidad_mult_div
module tb_unidad_mult_div;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        busy;
    logic        done;
    logic        dz;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        we_hi = 1'b0;
    logic        we_lo = 1'b0;
    int          n_tests = 0;
    int          n_fail = 0;

    unidad_mult_div dut (
`ifdef MD_MTHILO_EN
        .we_hi_i(we_hi),
        .we_lo_i(we_lo),
`endif
        .clk_i(clk),
        .rst_i(rst),
        .start_i(start),
        .op_i(op),
        .operand_a_i(a),
        .operand_b_i(b),
        .busy_o(busy),
        .done_o(done),
        .div_zero_o(dz),
        .hi_o(hi),
        .lo_o(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge in IDLE (or the DONE cycle); returns at the negedge where DONE is seen.
    // inj >= 0 pulses a conflicting START that many cycles into the operation.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] ehi, input logic [31:0] elo, input logic edz,
                          input int elat, input int inj);
        int lat;
        start = 1'b1;
        op = o;
        a = x;
        b = y;
        @(negedge clk);
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        chk({tag, " busy_on"}, 64'(busy), 64'd1);
        chk({tag, " done_low"}, 64'(done), 64'd0);
        lat = 0;
        while (!done && lat < 60) begin
            if (lat == inj) begin
                start = 1'b1;
                op = 2'b01;
                a = 32'hFFFF_FFFF;
                b = 32'hFFFF_FFFF;
            end
            @(negedge clk);
            start = 1'b0;
            lat++;
        end
        chk({tag, " latency"}, 64'(lat), 64'(elat));
        chk({tag, " busy_off"}, 64'(busy), 64'd0);
        chk({tag, " hi"}, 64'(hi), 64'(ehi));
        chk({tag, " lo"}, 64'(lo), 64'(elo));
        chk({tag, " div_zero"}, 64'(dz), 64'(edz));
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst done", 64'(done), 64'd0);
        chk("rst dz", 64'(dz), 64'd0);
        chk("rst hi", 64'(hi), 64'd0);
        chk("rst lo", 64'(lo), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33, -1);
        @(negedge clk);
        chk("done_pulse", 64'(done), 64'd0);
        run_op("mult_neg", 2'b00, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 33, -1);
        run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33, -1);
        run_op("div_negb", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0, 33, -1);
        run_op("divu", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33, -1);
        run_op("divu_zero", 2'b11, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, 1, -1);
        run_op("mult_clr_dz", 2'b00, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 33, -1);
        run_op("div_zero_s", 2'b10, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1, 1, -1);
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 33, -1);
        run_op("ignored_start", 2'b11, 32'd1000, 32'd7, 32'd6, 32'd142, 1'b0, 33, 10);
        run_op("b2b_first", 2'b01, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0, 1'b0, 33, -1);
        run_op("b2b_second", 2'b10, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 1'b0, 33, -1);
        @(negedge clk);
        start = 1'b1;
        op = 2'b10;
        a = 32'hFFFF_FFF9;
        b = 32'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        chk("pre_rst busy", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        chk("abort busy", 64'(busy), 64'd0);
        chk("abort hi", 64'(hi), 64'd0);
        chk("abort lo", 64'(lo), 64'd0);
        chk("abort done", 64'(done), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
`ifdef MD_MTHILO_EN
        we_hi = 1'b1;
        a = 32'h1234_5678;
        @(negedge clk);
        we_hi = 1'b0;
        chk("mthi hi", 64'(hi), 64'h1234_5678);
        chk("mthi lo", 64'(lo), 64'd0);
        chk("mthi done", 64'(done), 64'd0);
        we_lo = 1'b1;
        a = 32'hCAFE_0001;
        @(negedge clk);
        we_lo = 1'b0;
        chk("mtlo lo", 64'(lo), 64'hCAFE_0001);
        chk("mtlo hi", 64'(hi), 64'h1234_5678);
        we_hi = 1'b1;
        we_lo = 1'b1;
        run_op("start_wins", 2'b01, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 33, -1);
        we_hi = 1'b0;
        we_lo = 1'b0;
        @(negedge clk);
        chk("after_we hi", 64'(hi), 64'd0);
        chk("after_we lo", 64'(lo), 64'd6);
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
